// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding
// and the operand-type codes shared with the execute-stage decoder.
package div_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

  localparam logic DIV_UNSIGNED = 1'b0;
  localparam logic DIV_SIGNED   = 1'b1;

endpackage

// File: rtl/div_seq_if.sv
// Start/done handshake between the execute stage (master) and the divider (slave).
interface div_seq_if #(
  parameter int N_BIT = 4
);

  logic             start;
  logic [N_BIT-1:0] A;
  logic [N_BIT-1:0] B;
  logic             div_type;
  logic             busy;
  logic             done;
  logic [N_BIT-1:0] quotient;
  logic [N_BIT-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, A, B, div_type,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, A, B, div_type,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_seq_step.sv
// One combinational restoring-division step: shift in the next dividend bit
// and subtract the divisor when the result stays non-negative.
module div_step #(
  parameter int N_BIT = 4
) (
  input  logic [N_BIT-1:0] i_rem,
  input  logic             i_dvd_msb,
  input  logic [N_BIT-1:0] i_dvs,
  output logic [N_BIT-1:0] o_rem,
  output logic             o_qbit
);

  logic [N_BIT:0] w_shift;
  logic [N_BIT:0] w_trial;

  // The extra top bit of the trial acts as the borrow flag.
  assign w_shift = {i_rem, i_dvd_msb};
  assign w_trial = w_shift - {1'b0, i_dvs};
  assign o_qbit  = ~w_trial[N_BIT];
  assign o_rem   = o_qbit ? w_trial[N_BIT-1:0] : w_shift[N_BIT-1:0];

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit per clock, with signed
// fix-up and fixed latency for every operand combination.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int N_BIT = 4
) (
  input logic      clk,
  input logic      rst,
  div_seq_if.slave bus
);

  localparam int CNT_W = $clog2(N_BIT + 1);
  localparam logic [N_BIT-1:0] ONE  = N_BIT'(1);
  localparam logic [N_BIT-1:0] ZERO = {N_BIT{1'b0}};
  localparam logic [N_BIT-1:0] ONES = {N_BIT{1'b1}};

  div_state_t       r_state;
  div_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [N_BIT-1:0] r_rem;
  logic [N_BIT-1:0] r_dvd;
  logic [N_BIT-1:0] r_dvs;
  logic [N_BIT-1:0] r_a_raw;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_busy;
  logic             r_done;
  logic [N_BIT-1:0] r_quot;
  logic [N_BIT-1:0] r_rem_out;
  logic             r_dbz;

  logic [N_BIT-1:0] w_rem_nxt;
  logic             w_qbit;
  logic             w_signed;
  logic             w_dvs_zero;
  logic [N_BIT-1:0] w_quot_fix;
  logic [N_BIT-1:0] w_rem_fix;

  // Magnitude of a possibly signed operand; the most negative value maps to
  // its unsigned magnitude in the same width.
  function automatic logic [N_BIT-1:0] mag(input logic [N_BIT-1:0] v, input logic sgn);
    return (sgn && v[N_BIT-1]) ? (~v + ONE) : v;
  endfunction

  div_step #(.N_BIT(N_BIT)) u_step (
    .i_rem     (r_rem),
    .i_dvd_msb (r_dvd[N_BIT-1]),
    .i_dvs     (r_dvs),
    .o_rem     (w_rem_nxt),
    .o_qbit    (w_qbit)
  );

  assign w_signed   = (bus.div_type == DIV_SIGNED);
  assign w_dvs_zero = (r_dvs == ZERO);

  // Final result selection: divide-by-zero overrides the signed fix-up.
  always_comb begin
    w_quot_fix = r_dvd;
    w_rem_fix  = r_rem;
    if (w_dvs_zero) begin
      w_quot_fix = ONES;
      w_rem_fix  = r_a_raw;
    end else begin
      w_quot_fix = r_neg_q ? (~r_dvd + ONE) : r_dvd;
      w_rem_fix  = r_neg_r ? (~r_rem + ONE) : r_rem;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_FIX;
        end else begin
          w_state_nxt = S_CALC;
        end
      end
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= {CNT_W{1'b0}};
      r_rem     <= ZERO;
      r_dvd     <= ZERO;
      r_dvs     <= ZERO;
      r_a_raw   <= ZERO;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_quot    <= ZERO;
      r_rem_out <= ZERO;
      r_dbz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_cnt   <= CNT_W'(N_BIT);
            r_rem   <= ZERO;
            r_dvd   <= mag(bus.A, w_signed);
            r_dvs   <= mag(bus.B, w_signed);
            r_a_raw <= bus.A;
            r_neg_q <= w_signed & (bus.A[N_BIT-1] ^ bus.B[N_BIT-1]);
            r_neg_r <= w_signed & bus.A[N_BIT-1];
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt - CNT_W'(1);
          r_rem <= w_rem_nxt;
          r_dvd <= {r_dvd[N_BIT-2:0], w_qbit};
        end
        S_FIX: begin
          r_quot    <= w_quot_fix;
          r_rem_out <= w_rem_fix;
          r_dbz     <= w_dvs_zero;
        end
        S_DONE: begin
          r_cnt <= {CNT_W{1'b0}};
        end
        default: begin
          r_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Handshake flags registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_CALC) || (w_state_nxt == S_FIX);
      r_done <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem_out;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: stimulus queues expected results and the
// done cycle; a negedge monitor pops and compares on each done pulse.
module tb_div_seq;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       z;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_err;
  exp_t sb[$];
  exp_t e;

  div_seq_if #(.N_BIT(4)) bus ();

  div_seq #(.N_BIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && cyc > sb[0].cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL done_timeout: no done by cycle %0d", sb[0].cyc);
        void'(sb.pop_front());
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: done=1 expected 0 at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("quotient", int'(bus.quotient), int'(e.q));
          check("remainder", int'(bus.remainder), int'(e.r));
          check("div_by_zero", int'(bus.div_by_zero), int'(e.z));
          check("busy_at_done", int'(bus.busy), 0);
        end
      end
    end
  end

  // Present one start pulse; the result is due 6 cycles after the sampling cycle.
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic t,
                       input logic [3:0] q, input logic [3:0] r, input logic z);
    exp_t x;
    @(posedge clk);
    #1;
    bus.start    = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.div_type = t;
    x.q = q; x.r = r; x.z = z; x.cyc = cyc + 6;
    sb.push_back(x);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run(input logic [3:0] a, input logic [3:0] b, input logic t,
                     input logic [3:0] q, input logic [3:0] r, input logic z);
    issue(a, b, t, q, r, z);
    wait_idle();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    rst   = 1'b1;
    bus.start    = 1'b0;
    bus.A        = 4'h0;
    bus.B        = 4'h0;
    bus.div_type = 1'b0;
    #3;
    check("rst_quotient", int'(bus.quotient), 0);
    check("rst_remainder", int'(bus.remainder), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_dbz", int'(bus.div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run(4'd13, 4'd3, 1'b0, 4'h4, 4'h1, 1'b0);
    run(4'b1001, 4'h2, 1'b1, 4'hD, 4'hF, 1'b0);
    run(4'h7, 4'hE, 1'b1, 4'hD, 4'h1, 1'b0);
    run(4'h9, 4'h0, 1'b0, 4'hF, 4'h9, 1'b1);
    run(4'h9, 4'h0, 1'b1, 4'hF, 4'h9, 1'b1);
    run(4'h8, 4'hF, 1'b1, 4'h8, 4'h0, 1'b0);
    run(4'hF, 4'h4, 1'b0, 4'h3, 4'h3, 1'b0);
    run(4'h8, 4'h3, 1'b1, 4'hE, 4'hE, 1'b0);
    run(4'h8, 4'hF, 1'b0, 4'h0, 4'h8, 1'b0);
    run(4'hF, 4'hF, 1'b0, 4'h1, 4'h0, 1'b0);

    // Start while busy must be ignored.
    issue(4'd13, 4'd3, 1'b0, 4'h4, 4'h1, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("busy_mid_op", int'(bus.busy), 1);
    bus.start = 1'b1;
    bus.A     = 4'd15;
    bus.B     = 4'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    check("held_quotient", int'(bus.quotient), 4);
    run(4'd15, 4'd1, 1'b0, 4'hF, 4'h0, 1'b0);

    // Reset during the second CALC cycle aborts without a done.
    issue(4'd13, 4'd3, 1'b0, 4'h4, 4'h1, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("abort_quotient", int'(bus.quotient), 0);
    check("abort_remainder", int'(bus.remainder), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    run(4'd6, 4'd2, 1'b0, 4'h3, 4'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Sequential restoring divider for the tiny processor datapath; the inverse operation to the combinational array multiplier.
- Computes an N_BIT quotient and remainder, one quotient bit per clock.
- Supports unsigned and two's-complement signed operands.
- Driven by the execute stage through a start/done handshake.

Parameters:
- N_BIT, 4, operand/quotient/remainder width.
- CNT_W, $clog2(N_BIT+1), width of the iteration counter (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- A  input  N_BIT  dividend, sampled with start.
- B  input  N_BIT  divisor, sampled with start.
- div_type  input  1  0 = unsigned, 1 = signed; sampled with start.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  N_BIT  result quotient; held until the next accepted start.
- remainder  output  N_BIT  result remainder; held until the next accepted start.
- div_by_zero  output  1  set with done when B == 0; held like the results.

Behaviour:
- Reset (async, rst=1):
  - state = IDLE.
  - busy, done, quotient, remainder, div_by_zero = 0.
  - Counter and internal registers = 0.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - On start=1, latch A, B and div_type.
  - In signed mode, store |A| and |B|, plus sign flags neg_q = A[MSB]^B[MSB] and neg_r = A[MSB].
  - Clear the partial remainder, set the counter to N_BIT, and go to CALC. busy=1 from the next cycle.
- CALC: one restoring step per cycle.
  - Shift {rem, dividend} left by 1.
  - Trial = rem - divisor, computed at N_BIT+1 bits.
  - If trial is non-negative, rem = trial and the quotient LSB = 1; else keep rem and the quotient LSB = 0.
  - Counter decrements; at 1 go to FIX.
  - Exactly N_BIT CALC cycles.
- FIX:
  - Signed mode: negate the quotient if neg_q, negate the remainder if neg_r.
  - Register the final quotient and remainder to the outputs. Go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0, then IDLE.
  - done is high N_BIT+2 cycles after the cycle in which start was sampled.
  - A start in the DONE cycle is ignored.
- Latency is fixed and independent of operand values, including the special cases.
- Divide by zero (B==0, either mode): quotient = all ones, remainder = A unmodified, div_by_zero=1. Same latency.
- Signed overflow (A = most negative, B = -1): quotient = A, remainder = 0, div_by_zero=0.
- Signed rounding: the quotient truncates toward zero; the remainder takes the sign of the dividend; remainder magnitude < |B|.
- Width rule: the absolute value of the most negative operand is taken as an N_BIT unsigned magnitude (e.g. -8 -> 8 for N_BIT=4). No extra bit is needed except in the N_BIT+1-bit trial subtraction.
- start while busy=1 is ignored: no restart, no effect on the running operation.
- Results and div_by_zero update only in FIX; they are stable from done until the next start is accepted.
- Reset asserted mid-operation aborts immediately to the reset values. No done is produced.

Decomposition:
- Shared package/include:
  - State encoding localparams: S_IDLE, S_CALC, S_FIX, S_DONE.
  - DIV_UNSIGNED=0 and DIV_SIGNED=1, also used by the execute-stage decoder alongside the multiplier's mul_type.
- Sub-module div_step: purely combinational single restoring step.
  - Inputs: rem, dividend MSB, divisor.
  - Outputs: new rem, quotient bit.
  - Instantiated once; the sequencing FSM, counter and sign fix-up stay in div_seq.

Test Plan:
- Unsigned, N_BIT=4: A=13, B=3, div_type=0 -> done 6 cycles after start; quotient=4'h4, remainder=4'h1, div_by_zero=0.
- Signed: A=4'b1001 (-7), B=4'h2 -> quotient=4'hD (-3), remainder=4'hF (-1). Also A=7, B=-2 -> quotient=4'hD, remainder=4'h1.
- Divide by zero: A=9, B=0, either div_type -> quotient=4'hF, remainder=4'h9, div_by_zero=1, same 6-cycle latency.
- Signed overflow: A=4'h8 (-8), B=4'hF (-1) -> quotient=4'h8, remainder=4'h0, div_by_zero=0.
- Start while busy:
  - Issue 13/3, then pulse start with 15/1 on the third busy cycle.
  - Required: a single done, result 4/1; a subsequent accepted start gives 15/1 -> quotient=4'hF, remainder=0.
- Reset mid-operation:
  - Assert rst during the second CALC cycle.
  - Required: outputs 0 asynchronously, no done pulse.
  - After release, a new start with 6/2 gives quotient=3, remainder=0.
